// File: rtl/vending_machine_multi.sv
`default_nettype none
// ============================================================================
// vending_machine_multi : multi-product vending controller with credit
// ceiling, per-product stock/price checks, cancel/refund and largest-coin-first change.
// Revision 1.0
// ============================================================================
module vending_machine_multi #(
  parameter int NUM_PRODUCTS = 4,
  parameter int CREDIT_W     = 8,
  parameter int MAX_CREDIT   = 200,
  parameter logic [NUM_PRODUCTS*CREDIT_W-1:0] PRICES = {8'd100, 8'd65, 8'd50, 8'd25},
  parameter int SEL_W        = (NUM_PRODUCTS > 1) ? $clog2(NUM_PRODUCTS) : 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [1:0]              coin,
  input  logic [SEL_W-1:0]        select,
  input  logic                    button_press,
  input  logic                    cancel,
  input  logic [NUM_PRODUCTS-1:0] stock_empty,
  output logic                    release_soda,
  output logic [SEL_W-1:0]        release_sel,
  output logic [1:0]              change,
  output logic [CREDIT_W-1:0]     credit,
  output logic                    coin_reject,
  output logic                    deny,
  output logic                    busy
);

  localparam logic [1:0]        c_st_idle   = 2'd0;
  localparam logic [1:0]        c_st_vend   = 2'd1;
  localparam logic [1:0]        c_st_change = 2'd2;
  localparam logic [CREDIT_W:0] c_max_credit = (CREDIT_W+1)'(MAX_CREDIT);

  function automatic logic [CREDIT_W-1:0] coin_value(input logic [1:0] code);
    case (code)
      2'd1:    coin_value = CREDIT_W'(5);
      2'd2:    coin_value = CREDIT_W'(10);
      2'd3:    coin_value = CREDIT_W'(25);
      default: coin_value = '0;
    endcase
  endfunction

  function automatic logic [1:0] pick_coin(input logic [CREDIT_W-1:0] amt);
    if (amt >= CREDIT_W'(25))      pick_coin = 2'd3;
    else if (amt >= CREDIT_W'(10)) pick_coin = 2'd2;
    else if (amt >= CREDIT_W'(5))  pick_coin = 2'd1;
    else                           pick_coin = 2'd0;
  endfunction

  logic [1:0]          r_state, w_state_nxt;
  logic [CREDIT_W-1:0] r_remainder, w_remainder_nxt;
  logic [CREDIT_W-1:0] r_credit, w_credit_nxt;
  logic                r_release, w_release_nxt;
  logic [SEL_W-1:0]    r_release_sel, w_release_sel_nxt;
  logic [1:0]          r_change, w_change_nxt;
  logic                r_reject, w_reject_nxt;
  logic                r_deny, w_deny_nxt;
  logic                r_busy, w_busy_nxt;

  logic [CREDIT_W:0]   w_sum;
  logic                w_coin_fits;
  logic                w_sel_ok;
  logic                w_sel_empty;
  logic [CREDIT_W-1:0] w_price;
  logic                w_vend_ok;
  logic [CREDIT_W-1:0] w_pay_amt;
  logic [1:0]          w_pay_code;
  logic [CREDIT_W-1:0] w_pay_val;

  assign w_sum       = {1'b0, r_credit} + {1'b0, coin_value(coin)};
  assign w_coin_fits = (w_sum <= c_max_credit);

  // Matching by loop keeps out-of-range selects from indexing past the tables.
  always_comb begin
    w_sel_ok    = 1'b0;
    w_sel_empty = 1'b0;
    w_price     = '0;
    for (int i = 0; i < NUM_PRODUCTS; i++) begin
      if (select == SEL_W'(i)) begin
        w_sel_ok    = 1'b1;
        w_sel_empty = stock_empty[i];
        w_price     = PRICES[i*CREDIT_W +: CREDIT_W];
      end
    end
  end

  assign w_vend_ok  = button_press && w_sel_ok && !w_sel_empty && (r_credit >= w_price);
  // Next change coin comes from credit on a refund, otherwise from the remainder.
  assign w_pay_amt  = (r_state == c_st_idle) ? r_credit : r_remainder;
  assign w_pay_code = pick_coin(w_pay_amt);
  assign w_pay_val  = coin_value(w_pay_code);

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state       <= c_st_idle;
      r_remainder   <= '0;
      r_credit      <= '0;
      r_release     <= 1'b0;
      r_release_sel <= '0;
      r_change      <= 2'd0;
      r_reject      <= 1'b0;
      r_deny        <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_remainder   <= w_remainder_nxt;
      r_credit      <= w_credit_nxt;
      r_release     <= w_release_nxt;
      r_release_sel <= w_release_sel_nxt;
      r_change      <= w_change_nxt;
      r_reject      <= w_reject_nxt;
      r_deny        <= w_deny_nxt;
      r_busy        <= w_busy_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_remainder_nxt = r_remainder;
    w_credit_nxt    = r_credit;
    case (r_state)
      c_st_idle: begin
        if (cancel) begin
          if (w_pay_code != 2'd0) begin
            w_state_nxt     = c_st_change;
            w_remainder_nxt = r_credit - w_pay_val;
            w_credit_nxt    = '0;
          end
        end else if (w_vend_ok) begin
          w_state_nxt     = c_st_vend;
          w_remainder_nxt = r_credit - w_price;
          w_credit_nxt    = '0;
        end else if ((coin != 2'd0) && w_coin_fits) begin
          w_credit_nxt = w_sum[CREDIT_W-1:0];
        end
      end
      c_st_vend, c_st_change: begin
        if (w_pay_code != 2'd0) begin
          w_state_nxt     = c_st_change;
          w_remainder_nxt = r_remainder - w_pay_val;
        end else begin
          w_state_nxt = c_st_idle;
        end
      end
      default: w_state_nxt = c_st_idle;
    endcase
  end

  always_comb begin
    w_release_nxt     = 1'b0;
    w_release_sel_nxt = '0;
    w_change_nxt      = 2'd0;
    w_reject_nxt      = 1'b0;
    w_deny_nxt        = 1'b0;
    w_busy_nxt        = (w_state_nxt != c_st_idle);
    case (r_state)
      c_st_idle: begin
        if (cancel) begin
          w_reject_nxt = (coin != 2'd0);
          w_change_nxt = w_pay_code;
        end else if (w_vend_ok) begin
          w_release_nxt     = 1'b1;
          w_release_sel_nxt = select;
          w_reject_nxt      = (coin != 2'd0);
        end else begin
          w_deny_nxt   = button_press;
          w_reject_nxt = (coin != 2'd0) && !w_coin_fits;
        end
      end
      c_st_vend, c_st_change: begin
        w_reject_nxt = (coin != 2'd0);
        w_change_nxt = w_pay_code;
      end
      default: ;
    endcase
  end

  assign release_soda = r_release;
  assign release_sel  = r_release_sel;
  assign change       = r_change;
  assign credit       = r_credit;
  assign coin_reject  = r_reject;
  assign deny         = r_deny;
  assign busy         = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_vending_machine_multi.sv
`default_nettype none
// Bench for vending_machine_multi: expected pulse events are queued with
// their due cycle; a negedge monitor matches every pulse the DUTs present.
module tb_vending_machine_multi;

  localparam int K_REL = 0;
  localparam int K_CHG = 1;
  localparam int K_REJ = 2;
  localparam int K_DNY = 3;
  localparam logic [1:0] N = 2'd1;
  localparam logic [1:0] D = 2'd2;
  localparam logic [1:0] Q = 2'd3;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset;
  logic [1:0] a_coin, a_sel;
  logic       a_btn, a_cnl;
  logic [3:0] a_empty;
  logic       a_rel, a_rej, a_deny, a_busy;
  logic [1:0] a_rsel, a_chg;
  logic [7:0] a_credit;

  logic [1:0] b_coin, b_sel;
  logic       b_btn, b_cnl;
  logic [2:0] b_empty;
  logic       b_rel, b_rej, b_deny, b_busy;
  logic [1:0] b_rsel, b_chg;
  logic [7:0] b_credit;

  vending_machine_multi dut_a (
    .clock(clock), .reset(reset), .coin(a_coin), .select(a_sel),
    .button_press(a_btn), .cancel(a_cnl), .stock_empty(a_empty),
    .release_soda(a_rel), .release_sel(a_rsel), .change(a_chg),
    .credit(a_credit), .coin_reject(a_rej), .deny(a_deny), .busy(a_busy)
  );

  vending_machine_multi #(
    .NUM_PRODUCTS(3),
    .PRICES({8'd65, 8'd50, 8'd25})
  ) dut_b (
    .clock(clock), .reset(reset), .coin(b_coin), .select(b_sel),
    .button_press(b_btn), .cancel(b_cnl), .stock_empty(b_empty),
    .release_soda(b_rel), .release_sel(b_rsel), .change(b_chg),
    .credit(b_credit), .coin_reject(b_rej), .deny(b_deny), .busy(b_busy)
  );

  typedef struct {int id; int kind; int val; int cyc;} ev_t;
  ev_t q[$];
  int  cyc    = 0;
  int  checks = 0;
  int  errors = 0;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic string kname(input int k);
    case (k)
      K_REL:   kname = "release";
      K_CHG:   kname = "change";
      K_REJ:   kname = "coin_reject";
      default: kname = "deny";
    endcase
  endfunction

  task automatic expect_ev(input int id, input int kind, input int val, input int dly);
    q.push_back('{id, kind, val, cyc + dly});
  endtask

  task automatic observe(input int id, input int kind, input int val);
    int idx = -1;
    for (int i = 0; i < q.size(); i++)
      if (idx < 0 && q[i].id == id && q[i].kind == kind) idx = i;
    checks++;
    if (idx < 0) begin
      errors++;
      $display("FAIL unexpected %s dut%0d: got value %0d at cycle %0d, required none",
               kname(kind), id, val, cyc);
    end else begin
      if (q[idx].val != val || q[idx].cyc != cyc) begin
        errors++;
        $display("FAIL %s dut%0d: got value %0d at cycle %0d, required value %0d at cycle %0d",
                 kname(kind), id, val, cyc, q[idx].val, q[idx].cyc);
      end
      q.delete(idx);
    end
  endtask

  always @(negedge clock) begin
    if (a_rel === 1'b1)  observe(0, K_REL, int'(a_rsel));
    if (a_chg != 2'd0)   observe(0, K_CHG, int'(a_chg));
    if (a_rej === 1'b1)  observe(0, K_REJ, 0);
    if (a_deny === 1'b1) observe(0, K_DNY, 0);
    if (b_rel === 1'b1)  observe(1, K_REL, int'(b_rsel));
    if (b_chg != 2'd0)   observe(1, K_CHG, int'(b_chg));
    if (b_rej === 1'b1)  observe(1, K_REJ, 0);
    if (b_deny === 1'b1) observe(1, K_DNY, 0);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic tick(input logic [1:0] c, input logic [1:0] s, input logic bt, input logic cn);
    a_coin = c; a_sel = s; a_btn = bt; a_cnl = cn;
    @(negedge clock);
    a_coin = 2'd0; a_btn = 1'b0; a_cnl = 1'b0;
  endtask

  task automatic btick(input logic [1:0] c, input logic [1:0] s, input logic bt, input logic cn);
    b_coin = c; b_sel = s; b_btn = bt; b_cnl = cn;
    @(negedge clock);
    b_coin = 2'd0; b_btn = 1'b0; b_cnl = 1'b0;
  endtask

  task automatic idle();
    tick(2'd0, 2'd0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b0;
    a_coin = Q; a_sel = 2'd0; a_btn = 1'b0; a_cnl = 1'b0; a_empty = 4'd0;
    b_coin = 2'd0; b_sel = 2'd0; b_btn = 1'b0; b_cnl = 1'b0; b_empty = 3'd0;
    repeat (2) @(negedge clock);
    chk("reset credit", int'(a_credit), 0);
    chk("reset busy", int'(a_busy), 0);
    chk("reset release", int'(a_rel), 0);
    chk("reset release_sel", int'(a_rsel), 0);
    chk("reset change", int'(a_chg), 0);
    chk("reset coin_reject", int'(a_rej), 0);
    chk("reset deny", int'(a_deny), 0);
    chk("reset credit b", int'(b_credit), 0);
    reset = 1'b1;
    a_coin = 2'd0;
    tick(Q, 2'd0, 1'b0, 1'b0);
    chk("first quarter credit", int'(a_credit), 25);

    // exact vend, product 1 at 50
    tick(Q, 2'd0, 1'b0, 1'b0);
    chk("two quarters credit", int'(a_credit), 50);
    expect_ev(0, K_REL, 1, 1);
    tick(2'd0, 2'd1, 1'b1, 1'b0);
    chk("exact vend credit", int'(a_credit), 0);
    chk("exact vend busy", int'(a_busy), 1);
    idle();
    chk("exact vend idle next", int'(a_busy), 0);

    // 75 credit, product 0 at 25: two quarters back
    repeat (3) tick(Q, 2'd0, 1'b0, 1'b0);
    chk("three quarters credit", int'(a_credit), 75);
    expect_ev(0, K_REL, 0, 1);
    expect_ev(0, K_CHG, 3, 2);
    expect_ev(0, K_CHG, 3, 3);
    tick(2'd0, 2'd0, 1'b1, 1'b0);
    idle(); idle();
    chk("change busy last coin", int'(a_busy), 1);
    idle();
    chk("change done busy", int'(a_busy), 0);

    // 100 credit, product 2 at 65: quarter then dime
    repeat (4) tick(Q, 2'd0, 1'b0, 1'b0);
    chk("four quarters credit", int'(a_credit), 100);
    expect_ev(0, K_REL, 2, 1);
    expect_ev(0, K_CHG, 3, 2);
    expect_ev(0, K_CHG, 2, 3);
    tick(2'd0, 2'd2, 1'b1, 1'b0);
    repeat (3) idle();
    chk("65 vend done busy", int'(a_busy), 0);
    chk("65 vend credit", int'(a_credit), 0);

    // denials
    tick(Q, 2'd0, 1'b0, 1'b0);
    expect_ev(0, K_DNY, 0, 1);
    tick(2'd0, 2'd3, 1'b1, 1'b0);
    chk("deny low credit keeps credit", int'(a_credit), 25);
    a_empty = 4'b0001;
    expect_ev(0, K_DNY, 0, 1);
    tick(2'd0, 2'd0, 1'b1, 1'b0);
    chk("deny empty keeps credit", int'(a_credit), 25);
    a_empty = 4'd0;
    expect_ev(0, K_DNY, 0, 1);
    tick(D, 2'd3, 1'b1, 1'b0);
    chk("deny with coin accepts coin", int'(a_credit), 35);

    // refund 35 = quarter + dime
    expect_ev(0, K_CHG, 3, 1);
    expect_ev(0, K_CHG, 2, 2);
    tick(2'd0, 2'd0, 1'b0, 1'b1);
    chk("refund clears credit", int'(a_credit), 0);
    idle();
    chk("refund busy", int'(a_busy), 1);
    idle();
    chk("refund done", int'(a_busy), 0);

    // ceiling 190, then refund 7 quarters + dime + nickel
    repeat (7) tick(Q, 2'd0, 1'b0, 1'b0);
    tick(D, 2'd0, 1'b0, 1'b0);
    tick(N, 2'd0, 1'b0, 1'b0);
    chk("credit 190", int'(a_credit), 190);
    expect_ev(0, K_REJ, 0, 1);
    tick(Q, 2'd0, 1'b0, 1'b0);
    chk("over ceiling keeps credit", int'(a_credit), 190);
    for (int k = 1; k <= 7; k++) expect_ev(0, K_CHG, 3, k);
    expect_ev(0, K_CHG, 2, 8);
    expect_ev(0, K_CHG, 1, 9);
    tick(2'd0, 2'd0, 1'b0, 1'b1);
    expect_ev(0, K_REJ, 0, 1);
    tick(N, 2'd0, 1'b0, 1'b0);
    tick(2'd0, 2'd0, 1'b1, 1'b0);
    tick(2'd0, 2'd0, 1'b0, 1'b1);
    repeat (5) idle();
    chk("190 refund last coin busy", int'(a_busy), 1);
    idle();
    chk("190 refund done", int'(a_busy), 0);
    chk("190 refund credit", int'(a_credit), 0);

    // cancel at zero credit does nothing
    tick(2'd0, 2'd0, 1'b0, 1'b1);
    chk("cancel zero busy", int'(a_busy), 0);
    chk("cancel zero credit", int'(a_credit), 0);

    // valid vend rejects a same-cycle coin
    repeat (2) tick(Q, 2'd0, 1'b0, 1'b0);
    expect_ev(0, K_REL, 1, 1);
    expect_ev(0, K_REJ, 0, 1);
    tick(D, 2'd1, 1'b1, 1'b0);
    chk("vend with coin credit", int'(a_credit), 0);
    idle();
    chk("vend with coin idle", int'(a_busy), 0);

    // exactly at the ceiling is accepted, one more nickel is not
    repeat (8) tick(Q, 2'd0, 1'b0, 1'b0);
    chk("credit at ceiling", int'(a_credit), 200);
    expect_ev(0, K_REJ, 0, 1);
    tick(N, 2'd0, 1'b0, 1'b0);
    chk("nickel over ceiling", int'(a_credit), 200);

    // reset during refund drops the remaining change
    expect_ev(0, K_CHG, 3, 1);
    expect_ev(0, K_CHG, 3, 2);
    tick(2'd0, 2'd0, 1'b0, 1'b1);
    idle();
    reset = 1'b0;
    idle();
    chk("reset mid change coin", int'(a_chg), 0);
    chk("reset mid change busy", int'(a_busy), 0);
    reset = 1'b1;
    idle();
    chk("after reset no change", int'(a_chg), 0);
    chk("after reset idle", int'(a_busy), 0);
    chk("after reset credit", int'(a_credit), 0);

    // three-product instance: select 3 is out of range even with credit
    repeat (4) btick(Q, 2'd0, 1'b0, 1'b0);
    chk("b credit 100", int'(b_credit), 100);
    expect_ev(1, K_DNY, 0, 1);
    btick(2'd0, 2'd3, 1'b1, 1'b0);
    chk("b out of range keeps credit", int'(b_credit), 100);
    expect_ev(1, K_REL, 0, 1);
    for (int k = 2; k <= 4; k++) expect_ev(1, K_CHG, 3, k);
    btick(2'd0, 2'd0, 1'b1, 1'b0);
    repeat (4) btick(2'd0, 2'd0, 1'b0, 1'b0);
    chk("b vend done", int'(b_busy), 0);

    repeat (3) @(negedge clock);
    foreach (q[i]) begin
      checks++;
      errors++;
      $display("FAIL missing %s dut%0d: required value %0d at cycle %0d, never seen",
               kname(q[i].kind), q[i].id, q[i].val, q[i].cyc);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
